keyed_step_counter: RTL and testbench

- Parametrised, key-locked accumulator/counter with a four-state control FSM and a windowed LED output.
- Sits in the obfuscation test suite as the next-generation locked counter. It adds configurable width, step size, direction and key width, plus a deterministic corrupted mode whenever the applied key differs from the golden key.
- Used as a benchmark target for locking and unlocking flows.

---
 rtl/keyed_step_counter.sv | 106 ++++++++++
 tb/tb_keyed_step_counter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/keyed_step_counter.sv
// Key-locked up/down step counter with a four-state control FSM and a led window.
// A wrong key inverts direction and scrambles both the step and the loaded value.
module keyed_step_counter #(
   parameter int                CNT_W    = 32,
   parameter int                LED_W    = 8,
   parameter int                LED_LSB  = 16,
   parameter int                STEP_W   = 8,
   parameter int                KEY_W    = 16,
   parameter logic [KEY_W-1:0]  KEY_GOLD = 16'h3362
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              enable,
   input  logic              dir,
   input  logic [CNT_W-1:0]  value,
   input  logic [STEP_W-1:0] step,
   input  logic [KEY_W-1:0]  k,
   output logic [CNT_W-1:0]  count_o,
   output logic [LED_W-1:0]  led,
   output logic [1:0]        state_o,
   output logic              done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [CNT_W-1:0]   r_count;
   logic [CNT_W-1:0]   w_count_next;
   logic               r_done;

   logic [KEY_W-1:0]   w_key_diff;
   logic               w_key_err;
   logic [STEP_W-1:0]  w_eff_step;
   logic [CNT_W-1:0]   w_step_ext;
   logic               w_eff_dir;
   logic [CNT_W-1:0]   w_load_mask;

   assign w_key_diff = k ^ KEY_GOLD;
   assign w_key_err  = |w_key_diff;
   assign w_eff_step = w_key_err ? (step ^ w_key_diff[STEP_W-1:0]) : step;
   assign w_step_ext = CNT_W'(w_eff_step);
   assign w_eff_dir  = dir ^ w_key_err;

   // Whole copies of the key difference tiled from bit 0; any leftover top bits stay clean.
   genvar gi;
   generate
      for (gi = 0; gi < CNT_W; gi++) begin : g_load_mask
         if (gi < (CNT_W / KEY_W) * KEY_W) begin : g_tap
            assign w_load_mask[gi] = w_key_diff[gi % KEY_W];
         end else begin : g_zero
            assign w_load_mask[gi] = 1'b0;
         end
      end
   endgenerate

   always_comb begin
      w_state_next = r_state;
      w_count_next = r_count;
      case (r_state)
         ST_IDLE: begin
            if (enable) w_state_next = ST_LOAD;
         end
         ST_LOAD: begin
            w_count_next = value ^ w_load_mask;
            w_state_next = ST_RUN;
         end
         ST_RUN: begin
            if (enable) begin
               w_count_next = w_eff_dir ? (r_count + w_step_ext) : (r_count - w_step_ext);
            end else begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
         r_done  <= (w_state_next == ST_DONE);
      end
   end

   assign count_o = r_count;
   assign led     = r_count[LED_LSB +: LED_W];
   assign state_o = r_state;
   assign done    = r_done;

endmodule

// File: tb/tb_keyed_step_counter.sv
// Directed bench for keyed_step_counter: hand-computed counts, states and done pulses.
module tb_keyed_step_counter;

   logic        CLK;
   logic        RST_N;
   logic        enable;
   logic        dir;
   logic [31:0] value;
   logic [7:0]  step;
   logic [15:0] k;
   logic [31:0] count_o;
   logic [7:0]  led;
   logic [1:0]  state_o;
   logic        done;

   int checks = 0;
   int errors = 0;

   keyed_step_counter dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .enable  (enable),
      .dir     (dir),
      .value   (value),
      .step    (step),
      .k       (k),
      .count_o (count_o),
      .led     (led),
      .state_o (state_o),
      .done    (done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // state, done, count in one go
   task automatic chk_sdc(input string tag, input logic [1:0] s, input logic d, input logic [31:0] c);
      chk({tag, "_state"}, 32'(state_o), 32'(s));
      chk({tag, "_done"},  32'(done),    32'(d));
      chk({tag, "_count"}, count_o,      c);
      $display("step %s: state=%0d done=%0b count=%h led=%h", tag, state_o, done, count_o, led);
   endtask

   initial begin
      RST_N = 1'b0; enable = 1'b0; dir = 1'b1; value = '0; step = '0; k = 16'h3362;
      #12;
      chk_sdc("rst", 2'd0, 1'b0, 32'h0);
      chk("rst_led", 32'(led), 32'h0);
      RST_N = 1'b1;
      tick();
      chk_sdc("idle_hold", 2'd0, 1'b0, 32'h0);

      // correct key, counting up across the led window boundary
      dir = 1'b1; value = 32'h0000_FFF0; step = 8'h10; enable = 1'b1;
      tick(); chk_sdc("up_load", 2'd1, 1'b0, 32'h0);
      tick(); chk_sdc("up_run0", 2'd2, 1'b0, 32'h0000_FFF0);
      tick(); chk_sdc("up_run1", 2'd2, 1'b0, 32'h0001_0000);
      chk("up_led", 32'(led), 32'h01);
      tick(); chk_sdc("up_run2", 2'd2, 1'b0, 32'h0001_0010);
      tick(); chk_sdc("up_run3", 2'd2, 1'b0, 32'h0001_0020);
      enable = 1'b0;
      tick(); chk_sdc("up_done", 2'd3, 1'b1, 32'h0001_0020);
      tick(); chk_sdc("up_idle", 2'd0, 1'b0, 32'h0001_0020);

      // downward wrap-around
      dir = 1'b0; value = 32'h0000_0005; step = 8'h08; enable = 1'b1;
      tick(); tick(); chk_sdc("wrap_run0", 2'd2, 1'b0, 32'h0000_0005);
      tick(); chk_sdc("wrap_run1", 2'd2, 1'b0, 32'hFFFF_FFFD);
      chk("wrap_led", 32'(led), 32'hFF);
      enable = 1'b0;
      tick(); chk_sdc("wrap_done", 2'd3, 1'b1, 32'hFFFF_FFFD);
      tick(); chk_sdc("wrap_idle", 2'd0, 1'b0, 32'hFFFF_FFFD);

      // wrong key: scrambled load, inverted direction, scrambled step
      k = 16'h3363; dir = 1'b1; value = 32'h0000_0100; step = 8'h10; enable = 1'b1;
      tick(); chk_sdc("wk_load", 2'd1, 1'b0, 32'hFFFF_FFFD);
      tick(); chk_sdc("wk_run0", 2'd2, 1'b0, 32'h0001_0101);
      tick(); chk_sdc("wk_run1", 2'd2, 1'b0, 32'h0001_00F0);
      enable = 1'b0;
      tick(); chk_sdc("wk_done", 2'd3, 1'b1, 32'h0001_00F0);
      tick(); chk_sdc("wk_idle", 2'd0, 1'b0, 32'h0001_00F0);

      // key pulled mid-RUN, then restored
      k = 16'h3362; dir = 1'b1; value = 32'h0000_1000; step = 8'h04; enable = 1'b1;
      tick(); tick(); chk_sdc("mk_run0", 2'd2, 1'b0, 32'h0000_1000);
      tick(); chk_sdc("mk_run1", 2'd2, 1'b0, 32'h0000_1004);
      tick(); chk_sdc("mk_run2", 2'd2, 1'b0, 32'h0000_1008);
      k = 16'h0000;
      tick(); chk_sdc("mk_bad", 2'd2, 1'b0, 32'h0000_0FA2);
      k = 16'h3362;
      tick(); chk_sdc("mk_fix", 2'd2, 1'b0, 32'h0000_0FA6);
      step = 8'h00;
      tick(); chk_sdc("mk_step0", 2'd2, 1'b0, 32'h0000_0FA6);
      enable = 1'b0;
      tick(); chk_sdc("mk_done", 2'd3, 1'b1, 32'h0000_0FA6);
      tick(); chk_sdc("mk_idle", 2'd0, 1'b0, 32'h0000_0FA6);

      // enable dropped while in LOAD
      value = 32'hABCD_1234; step = 8'h10; enable = 1'b1;
      tick(); chk_sdc("el_load", 2'd1, 1'b0, 32'h0000_0FA6);
      enable = 1'b0;
      tick(); chk_sdc("el_run", 2'd2, 1'b0, 32'hABCD_1234);
      tick(); chk_sdc("el_done", 2'd3, 1'b1, 32'hABCD_1234);
      tick(); chk_sdc("el_idle", 2'd0, 1'b0, 32'hABCD_1234);

      // asynchronous reset in the middle of RUN
      value = 32'h00AB_0000; step = 8'h01; dir = 1'b1; enable = 1'b1;
      tick(); tick(); tick(); chk_sdc("ar_run", 2'd2, 1'b0, 32'h00AB_0001);
      #2 RST_N = 1'b0;
      #1;
      chk_sdc("ar_rst", 2'd0, 1'b0, 32'h0);
      chk("ar_led", 32'(led), 32'h0);
      enable = 1'b0;
      tick(); RST_N = 1'b1;
      tick(); chk_sdc("ar_idle", 2'd0, 1'b0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
